cond_scan_kernel: RTL and testbench

//  Parametrised successor to the single-bit conditional-if kernel. Scans the first len_i entries of an

---
 rtl/cond_scan_kernel.sv | 179 +++++++++++++++++
 tb/tb_cond_scan_kernel.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_scan_kernel.sv
// -----------------------------------------------------------------------------
// cond_scan_kernel
//   Conditional scan kernel over an internal WIDTH x DEPTH array. On a start
//   pulse it walks the first len_i entries (clamped to DEPTH). Zero entries are
//   overwritten with init_i and counted; nonzero entries are summed. A host can
//   load and read back the array through the controlArr port, which stalls the
//   kernel while held.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   r_enable             start / restart pulse
//   init_i, len_i        replacement value and scan length, latched at start
//   controlArr           host owns the array port; kernel is frozen
//   controlArrWEnable_a  host write enable
//   controlArrAddr_a     host address
//   controlArrWData_a    host write data
//   controlArrRData_a    host read data, one cycle after the address; 0 when
//                        controlArr is low
//   w_enable             done flag, held until the next r_enable
//   result, zero_count   sum of nonzero entries / number of replaced entries
//   busy                 kernel is scanning (RD/EV/WR)
// -----------------------------------------------------------------------------
module cond_scan_kernel #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int SUM_W = WIDTH + AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r_enable,
    input  logic [WIDTH-1:0] init_i,
    input  logic [AW:0]      len_i,
    input  logic             controlArr,
    input  logic             controlArrWEnable_a,
    input  logic [AW-1:0]    controlArrAddr_a,
    input  logic [WIDTH-1:0] controlArrWData_a,
    output logic [WIDTH-1:0] controlArrRData_a,
    output logic             w_enable,
    output logic [SUM_W-1:0] result,
    output logic [AW:0]      zero_count,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, RD, EV, WR, DONE} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [AW-1:0]    index_q, index_d;
    logic [AW:0]      len_q, len_d;
    logic [WIDTH-1:0] init_q, init_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [AW:0]      count_q, count_d;
    logic [SUM_W-1:0] result_q, result_d;
    logic [AW:0]      zero_count_q, zero_count_d;
    logic             w_enable_q, w_enable_d;

    // Single-port array with registered read data
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] mem_rdata_q;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;

    logic [AW:0]      idx_inc;
    logic             advance;

    assign idx_inc = {1'b0, index_q} + (AW+1)'(1);

    // Host owns the port outright while controlArr is high; the kernel only
    // writes in WR, so a write deferred by a host stall lands on release.
    assign mem_addr  = controlArr ? controlArrAddr_a  : index_q;
    assign mem_wdata = controlArr ? controlArrWData_a : init_q;
    assign mem_we    = controlArr ? controlArrWEnable_a : (state_q == WR);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata_q <= mem[mem_addr];
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        len_d        = len_q;
        init_d       = init_q;
        sum_d        = sum_q;
        count_d      = count_q;
        result_d     = result_q;
        zero_count_d = zero_count_q;
        w_enable_d   = w_enable_q;
        advance      = 1'b0;

        if (r_enable) begin
            init_d     = init_i;
            len_d      = (len_i > DEPTH_L) ? DEPTH_L : len_i;
            sum_d      = '0;
            count_d    = '0;
            index_d    = '0;
            w_enable_d = 1'b0;
            if (len_d == '0) begin
                state_d      = DONE;
                result_d     = '0;
                zero_count_d = '0;
                w_enable_d   = 1'b1;
            end else begin
                state_d = RD;
            end
        end else if (controlArr) begin
            // The read data captured for EV is lost to the host, so fall back
            // to RD and re-issue the read once the port is released.
            if (state_q == EV) begin
                state_d = RD;
            end
        end else begin
            case (state_q)
                RD: state_d = EV;
                EV: begin
                    if (mem_rdata_q == '0) begin
                        state_d = WR;
                    end else begin
                        sum_d   = sum_q + SUM_W'(mem_rdata_q);
                        advance = 1'b1;
                    end
                end
                WR: begin
                    count_d = count_q + (AW+1)'(1);
                    advance = 1'b1;
                end
                default: ;
            endcase

            if (advance) begin
                if (idx_inc < len_q) begin
                    index_d = idx_inc[AW-1:0];
                    state_d = RD;
                end else begin
                    state_d      = DONE;
                    result_d     = sum_d;
                    zero_count_d = count_d;
                    w_enable_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            index_q      <= '0;
            len_q        <= '0;
            init_q       <= '0;
            sum_q        <= '0;
            count_q      <= '0;
            result_q     <= '0;
            zero_count_q <= '0;
            w_enable_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            len_q        <= len_d;
            init_q       <= init_d;
            sum_q        <= sum_d;
            count_q      <= count_d;
            result_q     <= result_d;
            zero_count_q <= zero_count_d;
            w_enable_q   <= w_enable_d;
        end
    end

    assign controlArrRData_a = controlArr ? mem_rdata_q : '0;
    assign w_enable          = w_enable_q;
    assign result            = result_q;
    assign zero_count        = zero_count_q;
    assign busy              = (state_q == RD) || (state_q == EV) || (state_q == WR);

endmodule

// File: tb/tb_cond_scan_kernel.sv
module tb_cond_scan_kernel;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int SUM_W = WIDTH + AW;

    logic             clk = 1'b0;
    logic             rst;
    logic             r_enable;
    logic [WIDTH-1:0] init_i;
    logic [AW:0]      len_i;
    logic             controlArr;
    logic             controlArrWEnable_a;
    logic [AW-1:0]    controlArrAddr_a;
    logic [WIDTH-1:0] controlArrWData_a;
    logic [WIDTH-1:0] controlArrRData_a;
    logic             w_enable;
    logic [SUM_W-1:0] result;
    logic [AW:0]      zero_count;
    logic             busy;

    cond_scan_kernel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .r_enable            (r_enable),
        .init_i              (init_i),
        .len_i               (len_i),
        .controlArr          (controlArr),
        .controlArrWEnable_a (controlArrWEnable_a),
        .controlArrAddr_a    (controlArrAddr_a),
        .controlArrWData_a   (controlArrWData_a),
        .controlArrRData_a   (controlArrRData_a),
        .w_enable            (w_enable),
        .result              (result),
        .zero_count          (zero_count),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model state
    int model_arr [DEPTH];
    int pend_arr  [DEPTH];
    int pend_woff [DEPTH];   // edge offset (from start) at which entry i is rewritten, 0 = none
    int rb        [DEPTH];
    bit pending   = 0;
    int cur_init  = 0;
    int run_k     = 0;
    int run_done  = 0;
    int new_res   = 0;
    int new_zc    = 0;
    int prev_res  = 0;
    int prev_zc   = 0;
    bit chk_en    = 0;
    bit exp_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Per-cycle comparison against the model's timeline of the current run
    always @(negedge clk) begin
        if (chk_en && edge_cnt >= run_k) begin
            exp_done = (edge_cnt >= run_done);
            chk("w_enable", w_enable, exp_done);
            chk("busy", busy, !exp_done);
            chk("result", result, exp_done ? new_res : prev_res);
            chk("zero_count", zero_count, exp_done ? new_zc : prev_zc);
        end
    end

    task automatic host_wr(input int addr, input int data);
        controlArr          = 1'b1;
        controlArrWEnable_a = 1'b1;
        controlArrAddr_a    = AW'(addr);
        controlArrWData_a   = WIDTH'(data);
        @(negedge clk);
        controlArrWEnable_a = 1'b0;
        controlArr          = 1'b0;
        model_arr[addr]     = data;
    endtask

    task automatic load_case2();
        host_wr(0, 3); host_wr(1, 0); host_wr(2, 5); host_wr(3, 0);
    endtask

    task automatic readback(input string tag);
        controlArr = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            controlArrAddr_a = AW'(i);
            @(negedge clk);
            rb[i] = int'(controlArrRData_a);
            chk($sformatf("%s_rd[%0d]", tag, i), controlArrRData_a, model_arr[i]);
        end
        controlArr = 1'b0;
        #1;
        chk({tag, "_rdata_gated"}, controlArrRData_a, 0);
    endtask

    // Commit the writes of an interrupted run that landed on or before edge e
    task automatic apply_abort(input int e);
        if (pending) begin
            for (int i = 0; i < DEPTH; i++)
                if (pend_woff[i] > 0 && run_k + pend_woff[i] <= e) model_arr[i] = cur_init;
        end
        pending = 0;
    endtask

    task automatic start_run(input int len, input int init, input bit timed, input int extra);
        int k, eff, off;
        k = edge_cnt + 1;
        apply_abort(k);
        eff = (len > DEPTH) ? DEPTH : len;
        off = 0; new_res = 0; new_zc = 0;
        pend_arr = model_arr;
        for (int i = 0; i < DEPTH; i++) pend_woff[i] = 0;
        for (int i = 0; i < eff; i++) begin
            if (model_arr[i] == 0) begin
                off += 3; pend_arr[i] = init; pend_woff[i] = off; new_zc++;
            end else begin
                off += 2; new_res += model_arr[i];
            end
        end
        pending  = 1;
        cur_init = init;
        run_k    = k;
        run_done = k + off + extra;
        chk_en   = timed;
        len_i    = (AW+1)'(len);
        init_i   = WIDTH'(init);
        r_enable = 1'b1;
        @(negedge clk);
        r_enable = 1'b0;
    endtask

    task automatic finish_run(input int stall_at, input int stall_len, output int obs);
        bit done = 0;
        obs = -1;
        for (int n = 0; n < 400 && !done; n++) begin
            if (stall_len > 0 && edge_cnt == run_k + stall_at) controlArr = 1'b1;
            if (stall_len > 0 && edge_cnt == run_k + stall_at + stall_len) controlArr = 1'b0;
            if (w_enable) begin
                done = 1;
                obs  = edge_cnt - run_k;
            end else begin
                @(negedge clk);
            end
        end
        controlArr = 1'b0;
        if (!done) chk("done_timeout", 0, 1);
        model_arr = pend_arr;
        pending   = 0;
        repeat (2) @(negedge clk);
        chk_en = 0;
        chk("final_result", result, new_res);
        chk("final_zero_count", zero_count, new_zc);
        prev_res = new_res;
        prev_zc  = new_zc;
    endtask

    int obs;

    initial begin
        rst = 1'b1; r_enable = 1'b0; init_i = '0; len_i = '0;
        controlArr = 1'b0; controlArrWEnable_a = 1'b0;
        controlArrAddr_a = '0; controlArrWData_a = '0;
        for (int i = 0; i < DEPTH; i++) model_arr[i] = 0;
        repeat (3) @(negedge clk);
        chk("reset_w_enable", w_enable, 0);
        chk("reset_busy", busy, 0);
        chk("reset_result", result, 0);
        chk("reset_zero_count", zero_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // Known array: [3,0,5,0] then nonzero fill
        load_case2();
        for (int i = 4; i < DEPTH; i++) host_wr(i, $urandom_range(1, 255));
        start_run(4, 7, 1, 0);
        finish_run(0, 0, obs);
        chk("case2_latency", obs, 10);
        chk("case2_result", result, 8);
        chk("case2_zero_count", zero_count, 2);
        readback("case2");
        chk("case2_lit1", rb[1], 7);
        chk("case2_lit3", rb[3], 7);

        // Zero length, then over-long length clamped to DEPTH
        start_run(0, 9, 1, 0);
        finish_run(0, 0, obs);
        chk("len0_latency", obs, 0);
        chk("len0_result", result, 0);
        readback("len0");
        host_wr(9, 0);
        start_run(20, 1, 1, 0);
        finish_run(0, 0, obs);
        chk("len20_zero_count", zero_count, 1);
        readback("len20");

        // Full-scale sum must not wrap
        for (int i = 0; i < DEPTH; i++) host_wr(i, 255);
        start_run(16, 1, 1, 0);
        finish_run(0, 0, obs);
        chk("all255_latency", obs, 32);
        chk("all255_result", result, 4080);
        chk("all255_zero_count", zero_count, 0);

        // Host stall for three cycles while the first element is in EV
        load_case2();
        start_run(4, 7, 1, 4);
        finish_run(1, 3, obs);
        chk("stall_latency", obs, 14);
        chk("stall_result", result, 8);
        readback("stall");

        // Restart mid-run: the write to entry 1 has landed, entry 3 has not
        load_case2();
        start_run(4, 7, 1, 0);
        repeat (4) @(negedge clk);
        start_run(4, 7, 1, 0);
        finish_run(0, 0, obs);
        chk("restart_result", result, 15);
        chk("restart_zero_count", zero_count, 1);
        readback("restart");

        // Asynchronous reset in the middle of a scan
        host_wr(1, 0);
        start_run(4, 7, 0, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_w_enable", w_enable, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_result", result, 0);
        chk("async_rst_zero_count", zero_count, 0);
        apply_abort(edge_cnt);
        prev_res = 0; prev_zc = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_w_enable", w_enable, 0);
        readback("post_rst");

        // Randomized runs, every other one with a host stall at a random point
        for (int it = 0; it < 12; it++) begin
            int len, init, sat, slen;
            for (int i = 0; i < DEPTH; i++)
                host_wr(i, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 255));
            len  = $urandom_range(0, 20);
            init = $urandom_range(0, 255);
            if (it % 2 == 1) begin
                sat  = $urandom_range(1, 8);
                slen = $urandom_range(1, 4);
                start_run(len, init, 0, 0);
                finish_run(sat, slen, obs);
            end else begin
                start_run(len, init, 1, 0);
                finish_run(0, 0, obs);
            end
            readback($sformatf("rand%0d", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
